// File: rtl/regfile_sb_if.sv
// Bus bundle between decode/writeback and the regfile_sb register file.
// master: the pipeline side that issues reads, writebacks, issues and control.
// slave : the register file itself.
// Signals: rs1/rs2 read indices + valids, src1/src2_value read data,
// rs1/rs2_busy hazard flags, rd/wr_en/result writeback, issue_valid/issue_rd
// scoreboard producer tracking, flush, clear_req/clear_busy soft-clear handshake.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              rs1_valid;
    logic              rs2_valid;
    logic [DATA_W-1:0] src1_value;
    logic [DATA_W-1:0] src2_value;
    logic              rs1_busy;
    logic              rs2_busy;
    logic [ADDR_W-1:0] rd;
    logic              wr_en;
    logic [DATA_W-1:0] result;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              flush;
    logic              clear_req;
    logic              clear_busy;

    modport master (
        output rs1, rs2, rs1_valid, rs2_valid, rd, wr_en, result,
               issue_valid, issue_rd, flush, clear_req,
        input  src1_value, src2_value, rs1_busy, rs2_busy, clear_busy
    );

    modport slave (
        input  rs1, rs2, rs1_valid, rs2_valid, rd, wr_en, result,
               issue_valid, issue_rd, flush, clear_req,
        output src1_value, src2_value, rs1_busy, rs2_busy, clear_busy
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with scoreboard and soft-clear sequencer.
// Two combinational read ports with write-through bypass, one synchronous
// write port, x0 hard-wired to zero. A busy bit per register marks pending
// writebacks and produces hazard flags. clear_req starts a sweep that zeroes
// x1..x(NREG-1), one per cycle, while clear_busy stalls upstream.
// Ports: clk, rst_n (async active-low), bus (regfile_sb_if.slave).
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_sb_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREG - 1);
    localparam logic [NREG-1:0]   ONE_HOT0  = NREG'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] idx_r;
    logic              clear_busy_r;
    logic [DATA_W-1:0] mem_r [NREG];
    logic [NREG-1:0]   busy_r;

    logic              idle_s;
    logic              write_s;
    logic [NREG-1:0]   clr_mask_s;
    logic [NREG-1:0]   set_mask_s;
    logic [NREG-1:0]   busy_next_s;
    logic [DATA_W-1:0] src1_s;
    logic [DATA_W-1:0] src2_s;

    assign idle_s  = (state_r == ST_IDLE);
    // Writebacks are dropped while the sweep owns the array.
    assign write_s = idle_s && bus.wr_en && (bus.rd != ZERO_IDX);

    // Read port 1: gating, x0, same-cycle bypass, then array.
    always_comb begin
        src1_s = {DATA_W{1'b0}};
        if (!bus.rs1_valid || (bus.rs1 == ZERO_IDX)) begin
            src1_s = {DATA_W{1'b0}};
        end else if (idle_s && bus.wr_en && (bus.rd == bus.rs1)) begin
            src1_s = bus.result;
        end else begin
            src1_s = mem_r[bus.rs1];
        end
    end

    // Read port 2: identical structure to port 1.
    always_comb begin
        src2_s = {DATA_W{1'b0}};
        if (!bus.rs2_valid || (bus.rs2 == ZERO_IDX)) begin
            src2_s = {DATA_W{1'b0}};
        end else if (idle_s && bus.wr_en && (bus.rd == bus.rs2)) begin
            src2_s = bus.result;
        end else begin
            src2_s = mem_r[bus.rs2];
        end
    end

    assign bus.src1_value = src1_s;
    assign bus.src2_value = src2_s;

    // A writeback landing this cycle satisfies the consumer via the bypass.
    assign bus.rs1_busy = idle_s && bus.rs1_valid && (bus.rs1 != ZERO_IDX) &&
                          busy_r[bus.rs1] && !(bus.wr_en && (bus.rd == bus.rs1));
    assign bus.rs2_busy = idle_s && bus.rs2_valid && (bus.rs2 != ZERO_IDX) &&
                          busy_r[bus.rs2] && !(bus.wr_en && (bus.rd == bus.rs2));
    assign bus.clear_busy = clear_busy_r;

    // Scoreboard next state: set mask applied after clear so a new producer wins.
    always_comb begin
        clr_mask_s  = (bus.wr_en && (bus.rd != ZERO_IDX)) ?
                      (ONE_HOT0 << bus.rd) : {NREG{1'b0}};
        set_mask_s  = (bus.issue_valid && (bus.issue_rd != ZERO_IDX)) ?
                      (ONE_HOT0 << bus.issue_rd) : {NREG{1'b0}};
        busy_next_s = busy_r;
        if (!idle_s) begin
            busy_next_s = busy_r;
        end else if (bus.flush || bus.clear_req) begin
            busy_next_s = {NREG{1'b0}};
        end else begin
            busy_next_s = (busy_r & ~clr_mask_s) | set_mask_s;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_next_s;
        end
    end

    // Register array: normal writeback in IDLE, sweep zeroing in CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (write_s) begin
            mem_r[bus.rd] <= bus.result;
        end else if (state_r == ST_CLEAR) begin
            mem_r[idx_r] <= {DATA_W{1'b0}};
        end
    end

    // Soft-clear sequencer; exit is by compare so idx never needs to wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= FIRST_IDX;
            clear_busy_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.clear_req) begin
                        state_r      <= ST_CLEAR;
                        idx_r        <= FIRST_IDX;
                        clear_busy_r <= 1'b1;
                    end else begin
                        state_r      <= ST_IDLE;
                        idx_r        <= FIRST_IDX;
                        clear_busy_r <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (idx_r == LAST_IDX) begin
                        state_r      <= ST_IDLE;
                        idx_r        <= FIRST_IDX;
                        clear_busy_r <= 1'b0;
                    end else begin
                        state_r      <= ST_CLEAR;
                        idx_r        <= idx_r + ADDR_W'(1);
                        clear_busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    idx_r        <= FIRST_IDX;
                    clear_busy_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
